qspi_slave: RTL and testbench

Quad-SPI responder: the far end of the team's 4-bit-wide QSPI master link. Oversamples the incoming `sclk`, `cs_n` and four MOSI lines on the local system clock. Reassembles received nibbles into bytes delivered on a valid/ready port, and shifts a locally supplied byte back onto four MISO lines. Sits behind the pads as the target model and as the front end of flash/peripheral emulators.

---
 rtl/qspi_pkg.sv | 10 +
 rtl/qspi_slave_if.sv | 24 ++
 rtl/qspi_sync_edge.sv | 38 +++
 rtl/qspi_slave.sv | 174 +++++++++++++++++
 tb/tb_qspi_slave.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/qspi_pkg.sv
// Shared types and constants for the quad-SPI responder.
`timescale 1ns/1ps
package qspi_pkg;

    typedef enum logic [1:0] {IDLE, NIB0, NIB1} qspi_slv_state_t;

    localparam logic [7:0]  QSPI_FILL_BYTE        = 8'hFF;
    localparam int unsigned QSPI_NIBBLES_PER_BYTE = 2;

endpackage

// File: rtl/qspi_slave_if.sv
// Byte-level TX/RX handshake bundle between the QSPI responder and its local client.
`timescale 1ns/1ps
interface qspi_slave_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_underrun;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_overrun;

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, tx_underrun, rx_data, rx_valid, rx_overrun
    );

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, tx_underrun, rx_data, rx_valid, rx_overrun
    );

endinterface

// File: rtl/qspi_sync_edge.sv
// Multi-stage synchronizer plus history flop; rise/fall are one-cycle strobes aligned with level.
`timescale 1ns/1ps
module qspi_sync_edge #(
    parameter int unsigned      WIDTH     = 1,
    parameter int unsigned      STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] hist_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= RESET_VAL;
            end
            hist_q <= RESET_VAL;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/qspi_slave.sv
// Quad-SPI responder: nibble-serial RX/TX over 4 lanes, oversampled on clk.
// Define QSPI_SLAVE_ECHO_EN to return the last received byte on TX underrun.
`timescale 1ns/1ps
module qspi_slave
    import qspi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic [3:0]  mosi,
    output logic [3:0]  miso,
    output logic        miso_oe,
    qspi_slave_if.slave bus
);

    localparam int unsigned NIB_W = 8 / QSPI_NIBBLES_PER_BYTE;

    logic [1:0]       ctl_level_unused, ctl_rise, ctl_fall;
    logic [NIB_W-1:0] mosi_s, mosi_rise_unused, mosi_fall_unused;
    logic             sclk_rise, sclk_fall, cs_rise, cs_fall;

    // cs_n resets high so an idle bus produces no strobe out of reset.
    qspi_sync_edge #(.WIDTH(2), .STAGES(SYNC_STAGES), .RESET_VAL(2'b10)) u_ctl_sync (
        .clk   (clk),
        .reset (reset),
        .din   ({cs_n, sclk}),
        .level (ctl_level_unused),
        .rise  (ctl_rise),
        .fall  (ctl_fall)
    );

    qspi_sync_edge #(.WIDTH(NIB_W), .STAGES(SYNC_STAGES), .RESET_VAL('0)) u_mosi_sync (
        .clk   (clk),
        .reset (reset),
        .din   (mosi),
        .level (mosi_s),
        .rise  (mosi_rise_unused),
        .fall  (mosi_fall_unused)
    );

    assign sclk_rise = ctl_rise[0];
    assign sclk_fall = ctl_fall[0];
    assign cs_rise   = ctl_rise[1];
    assign cs_fall   = ctl_fall[1];

    qspi_slv_state_t  state_q, state_d;
    logic [7:0]       tx_shift_q, tx_shift_d, hold_q, hold_d, rx_data_q, rx_data_d;
    logic             hold_full_q, hold_full_d, rx_valid_q, rx_valid_d;
    logic [NIB_W-1:0] rx_lo_q, rx_lo_d, miso_q, miso_d;
    logic             miso_oe_q, miso_oe_d, underrun_q, underrun_d, overrun_q, overrun_d;
    logic             do_load, byte_done;
    logic [7:0]       load_byte, fill_byte;

`ifdef QSPI_SLAVE_ECHO_EN
    assign fill_byte = rx_data_q;
`else
    assign fill_byte = QSPI_FILL_BYTE;
`endif

    always_comb begin
        state_d     = state_q;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_lo_d     = rx_lo_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q & ~bus.rx_ready;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        underrun_d  = 1'b0;
        overrun_d   = 1'b0;
        do_load     = 1'b0;
        byte_done   = 1'b0;
        load_byte   = fill_byte;

        if (bus.tx_valid && !hold_full_q) begin
            hold_d      = bus.tx_data;
            hold_full_d = 1'b1;
        end

        if (cs_rise) begin
            state_d   = IDLE;
            miso_oe_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        do_load   = 1'b1;
                        miso_oe_d = 1'b1;
                        state_d   = NIB0;
                    end
                end
                NIB0: begin
                    if (sclk_rise) begin
                        rx_lo_d = mosi_s;
                    end else if (sclk_fall) begin
                        miso_d  = tx_shift_q[7:NIB_W];
                        state_d = NIB1;
                    end
                end
                NIB1: begin
                    if (sclk_rise) begin
                        byte_done = 1'b1;
                    end else if (sclk_fall) begin
                        do_load = 1'b1;
                        state_d = NIB0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A byte offered in the same cycle as an empty-register load waits for the next boundary.
        if (do_load) begin
            if (hold_full_q) begin
                load_byte   = hold_q;
                hold_full_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
            tx_shift_d = load_byte;
            miso_d     = load_byte[NIB_W-1:0];
        end

        if (byte_done) begin
            if (!rx_valid_q || bus.rx_ready) begin
                rx_data_d  = {mosi_s, rx_lo_q};
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            tx_shift_q  <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            rx_lo_q     <= '0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            miso_q      <= '0;
            miso_oe_q   <= 1'b0;
            underrun_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_lo_q     <= rx_lo_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            underrun_q  <= underrun_d;
            overrun_q   <= overrun_d;
        end
    end

    assign miso            = miso_q;
    assign miso_oe         = miso_oe_q;
    assign bus.tx_ready    = ~hold_full_q;
    assign bus.tx_underrun = underrun_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.rx_overrun  = overrun_q;

endmodule

// File: tb/tb_qspi_slave.sv
// Self-checking bench for qspi_slave: a QSPI master model drives the pins and a byte-level
// reference model predicts MISO bytes, RX handshake state and underrun/overrun pulse counts.
`timescale 1ns/1ps
module tb_qspi_slave;
    import qspi_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic [3:0] mosi = 4'h0;
    logic [3:0] miso;
    logic       miso_oe;

    qspi_slave_if bus();

    qspi_slave #(.SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .sclk    (sclk),
        .cs_n    (cs_n),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;
    int und_cnt  = 0;
    int ovr_cnt  = 0;

    always @(posedge clk) begin
        if (bus.tx_underrun) und_cnt <= und_cnt + 1;
        if (bus.rx_overrun)  ovr_cnt <= ovr_cnt + 1;
    end

    // Reference model state
    logic [7:0] m_rx_data = 8'h00;
    logic       m_rx_valid = 1'b0;
    int         m_und, m_ovr, s_idx;
    logic [7:0] mq[$];
    logic [7:0] sq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_load(output logic [7:0] b);
        if (s_idx < sq.size()) begin
            b = sq[s_idx];
            s_idx++;
        end else begin
            m_und++;
`ifdef QSPI_SLAVE_ECHO_EN
            b = m_rx_data;
`else
            b = QSPI_FILL_BYTE;
`endif
        end
    endtask

    task automatic model_complete(input logic [7:0] b, input logic rdy);
        if (m_rx_valid && !rdy) begin
            m_ovr++;
        end else begin
            m_rx_data  = b;
            m_rx_valid = !rdy;
        end
    endtask

    task automatic push(input logic [7:0] b);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (bus.tx_ready) begin
                #10;
                bus.tx_valid = 1'b0;
                return;
            end
            #10;
        end
        bus.tx_valid = 1'b0;
        check("push_timeout", bus.tx_ready, 1);
    endtask

    // One burst: mq holds master bytes, sq the bytes handed to the TX port.
    // The falling edge after the last nibble is also a byte boundary, so it performs a load too.
    task automatic xfer(input logic rdy);
        logic [7:0] exp_tx;
        int u0, o0;
        m_und = 0;
        m_ovr = 0;
        s_idx = 0;
        u0 = und_cnt;
        o0 = ovr_cnt;
        bus.rx_ready = rdy;
        if (rdy) m_rx_valid = 1'b0;
        if (sq.size() > 0) begin
            push(sq[0]);
            check("hold_full", bus.tx_ready, 0);
        end else begin
            #10;
        end
        cs_n = 1'b0;
        model_load(exp_tx);
        #60;
        check("oe_on", miso_oe, 1);
        check("tx_ready_csfall", bus.tx_ready, 1);
        for (int i = 0; i < mq.size(); i++) begin
            if (i + 1 < sq.size()) push(sq[i+1]);
            mosi = mq[i][3:0];
            #20 sclk = 1'b1;
            #40 check("miso_lo", miso, exp_tx[3:0]);
            sclk = 1'b0;
            #40 mosi = mq[i][7:4];
            #20 sclk = 1'b1;
            #40 check("miso_hi", miso, exp_tx[7:4]);
            model_complete(mq[i], rdy);
            sclk = 1'b0;
            model_load(exp_tx);
            #40;
        end
        #20 cs_n = 1'b1;
        #60;
        check("oe_off", miso_oe, 0);
        check("rx_valid", bus.rx_valid, m_rx_valid);
        check("rx_data", bus.rx_data, m_rx_data);
        check("underruns", und_cnt - u0, m_und);
        check("overruns", ovr_cnt - o0, m_ovr);
        check("tx_ready_end", bus.tx_ready, 1);
        bus.rx_ready = 1'b0;
    endtask

    task automatic take();
        check("take_valid", bus.rx_valid, m_rx_valid);
        check("take_data", bus.rx_data, m_rx_data);
        bus.rx_ready = 1'b1;
        #10 bus.rx_ready = 1'b0;
        m_rx_valid = 1'b0;
        #10 check("take_clear", bus.rx_valid, 0);
    endtask

    task automatic abort_xfer(input logic [3:0] nib);
        int u0;
        u0 = und_cnt;
        cs_n = 1'b0;
        #60 mosi = nib;
        #20 sclk = 1'b1;
        #40 sclk = 1'b0;
        #40 cs_n = 1'b1;
        #60;
        check("abort_rx_valid", bus.rx_valid, m_rx_valid);
        check("abort_idle", dut.state_q, IDLE);
        check("abort_underrun", und_cnt - u0, 1);
    endtask

    task automatic reset_mid();
        cs_n = 1'b0;
        #60 mosi = 4'h7;
        #20 sclk = 1'b1;
        #40 sclk = 1'b0;
        #20 reset = 1'b1;
        #20;
        check("mid_rst_miso", miso, 0);
        check("mid_rst_oe", miso_oe, 0);
        check("mid_rst_rx_valid", bus.rx_valid, 0);
        check("mid_rst_rx_data", bus.rx_data, 0);
        check("mid_rst_tx_ready", bus.tx_ready, 1);
        check("mid_rst_idle", dut.state_q, IDLE);
        cs_n = 1'b1;
        #20 reset = 1'b0;
        m_rx_data  = 8'h00;
        m_rx_valid = 1'b0;
        #40;
    endtask

    initial begin
        int n, s;
        logic r;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        bus.rx_ready = 1'b0;
        #50 reset = 1'b0;
        #20;
        check("rst_miso", miso, 0);
        check("rst_oe", miso_oe, 0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_tx_ready", bus.tx_ready, 1);
        check("rst_underrun", bus.tx_underrun, 0);
        check("rst_overrun", bus.rx_overrun, 0);

        mq = {8'hA5}; sq = {};      xfer(1'b0); take();
        mq = {8'h00}; sq = {8'h3C}; xfer(1'b1);
        mq = {8'h12, 8'h34}; sq = {8'h11}; xfer(1'b1);
        mq = {8'h01, 8'h02}; sq = {};      xfer(1'b0); take();
        abort_xfer(4'h9);
        mq = {8'hC3}; sq = {}; xfer(1'b0); take();
        reset_mid();
        mq = {8'h5A}; sq = {}; xfer(1'b0); take();

        for (int t = 0; t < 30; t++) begin
            n = $urandom_range(1, 3);
            s = $urandom_range(0, n);
            r = 1'($urandom_range(0, 1));
            mq.delete();
            sq.delete();
            for (int k = 0; k < n; k++) mq.push_back(8'($urandom));
            for (int k = 0; k < s; k++) sq.push_back(8'($urandom));
            xfer(r);
            if ($urandom_range(0, 1) == 1) take();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
